// File: rtl/apb_slave_regfile_pkg.sv
// rtl/apb_slave_regfile_pkg.sv - shared APB types and default parameters
package apb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } apb_slv_state_t;

    localparam int APB_DATA_W      = 16;
    localparam int APB_ADDR_W      = 3;
    localparam int APB_DEPTH       = 4;
    localparam int APB_WAIT_THRESH = 255;
    localparam int APB_WAIT_CYCLES = 2;

    // Wait counter width: enough to hold WAIT_CYCLES, never narrower than 1 bit
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/apb_slave_regfile_if.sv
// rtl/apb_slave_regfile_if.sv - APB bus bundle between master/decoder and slave
interface apb_slave_regfile_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
);
    logic              Psel;
    logic              Penable;
    logic              Pwrite;
    logic [ADDR_W-1:0] Paddr;
    logic [DATA_W-1:0] Pwdata;
    logic [DATA_W-1:0] Prdata;
    logic              Pready;
    logic              Pslverr;

    modport master (
        output Psel, Penable, Pwrite, Paddr, Pwdata,
        input  Prdata, Pready, Pslverr
    );

    modport slave (
        input  Psel, Penable, Pwrite, Paddr, Pwdata,
        output Prdata, Pready, Pslverr
    );
endinterface

// File: rtl/apb_slave_regfile_timer.sv
// rtl/apb_slave_regfile_timer.sv - loadable down-counter timing slave wait states
module apb_wait_timer #(
    parameter int CW = 1
) (
    input  logic          Pclk,
    input  logic          Prst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          dec,
    output logic          zero
);
    logic [CW-1:0] cnt;

    always_ff @(posedge Pclk or negedge Prst) begin
        if (!Prst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);
endmodule

// File: rtl/apb_slave_regfile.sv
// rtl/apb_slave_regfile.sv - parametrised APB register file with data-dependent wait states
module apb_slave_regfile
    import apb_pkg::*;
#(
    parameter int DATA_W      = APB_DATA_W,
    parameter int ADDR_W      = APB_ADDR_W,
    parameter int DEPTH       = APB_DEPTH,
    parameter int WAIT_THRESH = APB_WAIT_THRESH,
    parameter int WAIT_CYCLES = APB_WAIT_CYCLES
) (
    input  logic               Pclk,
    input  logic               Prst,
    apb_slave_regfile_if.slave bus,
    output logic [DATA_W-1:0]  s2m
);
    localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int MEM_N = 1 << IW;
    localparam int CW    = cnt_w(WAIT_CYCLES);
    localparam logic [CW-1:0]     LOAD_VAL = CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
    localparam logic [DATA_W-1:0] THRESH   = DATA_W'(WAIT_THRESH);

    apb_slv_state_t state, next_state;

    logic [DATA_W-1:0] mem [MEM_N];
    logic [IW-1:0]     idx;
    logic              access, in_range, slow;
    logic [DATA_W-1:0] rd_word, cand;
    logic              zero, load, dec, we;
    logic              ready, slverr;
    logic [DATA_W-1:0] rdata;

    assign access   = bus.Psel & bus.Penable;
    assign idx      = bus.Paddr[IW-1:0];
    assign in_range = 32'(bus.Paddr) < DEPTH;
    assign rd_word  = in_range ? mem[idx] : '0;
    assign cand     = bus.Pwrite ? bus.Pwdata : rd_word;
    // Only meaningful in IDLE; WAIT never re-evaluates it
    assign slow     = (WAIT_CYCLES != 0) && (cand > THRESH);

    apb_wait_timer #(.CW(CW)) u_timer (
        .Pclk     (Pclk),
        .Prst     (Prst),
        .load     (load),
        .load_val (LOAD_VAL),
        .dec      (dec),
        .zero     (zero)
    );

    always_ff @(posedge Pclk or negedge Prst) begin
        if (!Prst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (access && in_range && slow) next_state = WAIT;
            WAIT: if (!access || zero)            next_state = IDLE;
            default:                              next_state = IDLE;
        endcase
    end

    always_comb begin
        ready  = 1'b0;
        slverr = 1'b0;
        rdata  = '0;
        we     = 1'b0;
        load   = 1'b0;
        dec    = 1'b0;
        if (Prst && access) begin
            case (state)
                IDLE: begin
                    if (!in_range) begin
                        ready  = 1'b1;
                        slverr = 1'b1;
                    end else if (!slow) begin
                        ready = 1'b1;
                        we    = bus.Pwrite;
                        rdata = bus.Pwrite ? '0 : rd_word;
                    end else begin
                        load = 1'b1;
                    end
                end
                WAIT: begin
                    if (zero) begin
                        ready = 1'b1;
                        we    = bus.Pwrite & in_range;
                        rdata = bus.Pwrite ? '0 : rd_word;
                    end else begin
                        dec = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Pclk or negedge Prst) begin
        if (!Prst) begin
            for (int i = 0; i < MEM_N; i++) mem[i] <= '0;
            s2m <= '0;
        end else if (we) begin
            mem[idx] <= bus.Pwdata;
            s2m      <= bus.Pwdata;
        end
    end

    assign bus.Pready  = ready;
    assign bus.Pslverr = slverr;
    assign bus.Prdata  = rdata;
endmodule

// File: tb/tb_apb_slave_regfile.sv
// tb/tb_apb_slave_regfile.sv - randomized self-checking bench for apb_slave_regfile
module tb_apb_slave_regfile;
    logic        clk = 1'b0;
    logic        prst = 1'b0;
    logic        sel2 = 1'b0;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [2:0]  paddr = '0;
    logic [31:0] pwdata = '0;
    logic [15:0] s2m1;
    logic [31:0] s2m2;

    int total = 0;
    int bad   = 0;

    logic [15:0] m1 [8];
    logic [31:0] m2 [8];
    logic [31:0] ms1, ms2;

    always #5 clk = ~clk;

    apb_slave_regfile_if #(.DATA_W(16), .ADDR_W(3)) b1 ();
    apb_slave_regfile_if #(.DATA_W(32), .ADDR_W(3)) b2 ();

    assign b1.Psel    = psel & ~sel2;
    assign b1.Penable = penable;
    assign b1.Pwrite  = pwrite;
    assign b1.Paddr   = paddr;
    assign b1.Pwdata  = pwdata[15:0];
    assign b2.Psel    = psel & sel2;
    assign b2.Penable = penable;
    assign b2.Pwrite  = pwrite;
    assign b2.Paddr   = paddr;
    assign b2.Pwdata  = pwdata;

    apb_slave_regfile #(.DATA_W(16), .ADDR_W(3), .DEPTH(4), .WAIT_THRESH(255), .WAIT_CYCLES(2)) dut (
        .Pclk (clk), .Prst (prst), .bus (b1), .s2m (s2m1)
    );

    apb_slave_regfile #(.DATA_W(32), .ADDR_W(3), .DEPTH(8), .WAIT_THRESH(255), .WAIT_CYCLES(0)) dut2 (
        .Pclk (clk), .Prst (prst), .bus (b2), .s2m (s2m2)
    );

    wire        rdy = sel2 ? b2.Pready  : b1.Pready;
    wire        err = sel2 ? b2.Pslverr : b1.Pslverr;
    wire [31:0] rdt = sel2 ? b2.Prdata  : {16'h0, b1.Prdata};
    wire [31:0] s2m = sel2 ? s2m2       : {16'h0, s2m1};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m1[i] = '0;
            m2[i] = '0;
        end
        ms1 = '0;
        ms2 = '0;
    endtask

    task automatic xfer(input bit wr, input int a, input logic [31:0] wd,
                        output logic [31:0] rd, output int waits, output bit e, output bit ok);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = 3'(a); pwdata = wd;
        @(negedge clk);
        check("setup_rdy", 64'(rdy), 64'd0);
        @(posedge clk); #1;
        penable = 1'b1;
        waits = 0; ok = 1'b0; rd = '0; e = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (rdy) begin
                rd = rdt; e = err; ok = 1'b1;
                break;
            end
            waits++;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    // Expected results follow directly from the register-file contract of each instance
    task automatic run(input bit wr, input int a, input logic [31:0] wd_in);
        logic [31:0] rd, cur, val, wd, erd;
        int          w, ew, depth, wc;
        bit          e, ok, in;
        depth = sel2 ? 8 : 4;
        wc    = sel2 ? 0 : 2;
        wd    = sel2 ? wd_in : {16'h0, wd_in[15:0]};
        in    = a < depth;
        cur   = !in ? 32'h0 : (sel2 ? m2[a] : {16'h0, m1[a]});
        val   = wr ? wd : cur;
        ew    = (in && wc != 0 && val > 255) ? wc : 0;
        erd   = (!wr && in) ? cur : 32'h0;
        xfer(wr, a, wd, rd, w, e, ok);
        check("done", 64'(ok), 64'd1);
        if (ok) begin
            check(wr ? "wr_waits" : "rd_waits", 64'(w), 64'(ew));
            check("slverr", 64'(e), 64'(!in));
            check("prdata", 64'(rd), 64'(erd));
        end
        if (wr && in) begin
            if (sel2) begin m2[a] = wd; ms2 = wd; end
            else begin m1[a] = wd[15:0]; ms1 = wd; end
        end
        check("s2m", 64'(s2m), 64'(sel2 ? ms2 : ms1));
    endtask

    task automatic start_slow_write();
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 3'd3; pwdata = 32'h0300;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        check("slow_first_rdy", 64'(rdy), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] d;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rdy", 64'(rdy), 64'd0);
        check("rst_rdata", 64'(rdt), 64'd0);
        check("rst_s2m", 64'(s2m), 64'd0);
        @(posedge clk); #1;
        prst = 1'b1;

        for (int a = 0; a < 4; a++) run(1'b0, a, 32'h0);
        run(1'b1, 1, 32'h0042);
        run(1'b0, 1, 32'h0);
        run(1'b1, 2, 32'h1234);
        run(1'b0, 2, 32'h0);
        run(1'b1, 5, 32'h0011);
        run(1'b0, 5, 32'h0);
        run(1'b1, 3, 32'h00FF);
        run(1'b1, 0, 32'h0100);

        // Master abort while waiting: addr 3 must keep 0x00FF
        start_slow_write();
        psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        check("abort_rdy", 64'(rdy), 64'd0);
        run(1'b0, 3, 32'h0);

        // Reset during WAIT drops the pending write and clears everything
        start_slow_write();
        prst = 1'b0;
        @(negedge clk);
        check("midrst_rdy", 64'(rdy), 64'd0);
        check("midrst_s2m", 64'(s2m), 64'd0);
        psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        prst = 1'b1;
        model_reset();
        for (int a = 0; a < 4; a++) run(1'b0, a, 32'h0);

        for (int i = 0; i < 40; i++) begin
            d = $urandom;
            if ($urandom_range(0, 1) == 1) d = d % 300;
            run(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), d);
        end

        sel2 = 1'b1;
        run(1'b1, 7, 32'hFFFF_FFFF);
        run(1'b0, 7, 32'h0);
        for (int i = 0; i < 12; i++) begin
            run(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), $urandom);
        end
        sel2 = 1'b0;
        run(1'b0, 7, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/apb_slave_regfile.md
# apb_slave_regfile

Parametrised APB slave register file, the next generation of the fixed 4×16 slave that sits behind the APB master's address decoder. It adds configurable data width, address width and depth, and fully synchronous storage. Transfers whose data exceeds a threshold take a counted number of wait states. Out-of-range accesses are reported on Pslverr. A registered `s2m` monitor output returns the last written word to the master side.

## Interface
- DATA_W, 16: data bus and register width
- ADDR_W, 3: Paddr width
- DEPTH, 4: number of registers; must satisfy DEPTH ≤ 2^ADDR_W
- WAIT_THRESH, 255: data values strictly above this take wait states
- WAIT_CYCLES, 2: wait states inserted for a slow transfer; 0 disables waits

- Pclk  input  1  clock, all state changes on rising edge
- Prst  input  1  reset, asynchronous assert, active-low (0 = reset)
- Psel  input  1  slave select from decoder
- Penable  input  1  APB access phase
- Pwrite  input  1  1 = write, 0 = read
- Paddr  input  ADDR_W  register index
- Pwdata  input  DATA_W  write data
- Prdata  output  DATA_W  read data
- Pready  output  1  transfer completes on this cycle's rising edge
- Pslverr  output  1  error response, valid only while Pready = 1
- s2m  output  DATA_W  last successfully written word (registered)

## Operation
- Reset (Prst = 0): all registers = 0, s2m = 0, state = IDLE, counter = 0. Outputs Pready, Pslverr and Prdata = 0 while in reset.
- FSM has two states: IDLE and WAIT.
- **IDLE**, access phase (Psel & Penable), Paddr ≥ DEPTH:
  - Pready = 1, Pslverr = 1, Prdata = 0.
  - No register or s2m update.
  - Stay in IDLE.
- **IDLE**, access phase, in range, fast transfer:
  - Fast means: for writes, Pwdata ≤ WAIT_THRESH; for reads, mem[Paddr] ≤ WAIT_THRESH; or WAIT_CYCLES = 0.
  - Pready = 1 combinationally.
  - Write: mem[Paddr] and s2m ← Pwdata at the edge.
  - Read: Prdata = mem[Paddr].
- **IDLE**, access phase, in range, slow transfer:
  - Pready = 0.
  - If WAIT_CYCLES = 1, go straight to WAIT with cnt ← 0; otherwise cnt ← WAIT_CYCLES−1.
  - Next state = WAIT.
- **WAIT**, cnt ≠ 0: Pready = 0, cnt decrements.
- **WAIT**, cnt = 0:
  - Pready = 1, Pslverr = 0.
  - Commit the write, or drive Prdata = mem[Paddr], using the bus values current at that cycle.
  - Next state = IDLE.
- **WAIT**, Psel = 0 or Penable = 0 (master abort): return to IDLE, no commit, Pready stays 0.
- Outside a completing cycle, Prdata = 0 and Pslverr = 0.
- The slow/fast decision is taken once, at access-phase entry in IDLE. A later change of mem contents does not re-evaluate it.
- Comparisons are unsigned at DATA_W bits. The counter is $clog2(WAIT_CYCLES+1) bits wide, minimum 1.

## Timing
- Setup phase (Psel = 1, Penable = 0): no action, Pready = 0.
- Fast transfer: zero wait states. Pready is high in the first access cycle.
- Slow transfer: exactly WAIT_CYCLES access cycles with Pready = 0, then one cycle with Pready = 1. Total access phase is WAIT_CYCLES+1 cycles.
- Write data becomes visible to a read in the cycle after the completing edge. s2m updates on the same edge.
- Back-to-back transfers: after completion the FSM is in IDLE and accepts the next setup immediately.
- Reset asserted mid-WAIT: the FSM goes to IDLE at once and the pending write is lost.

## Structure
- Shared package `apb_pkg` holds:
  - the state typedef `apb_slv_state_t` (IDLE, WAIT);
  - default parameter constants APB_DATA_W, APB_ADDR_W, APB_WAIT_THRESH, APB_WAIT_CYCLES, shared with the master and decoder.
- One sub-module, `apb_wait_timer`: a loadable down-counter with `load`, `load_val` and `zero` ports, reset via Prst.
- The register array and FSM live in the top module.

## Test plan
- Reset: hold Prst = 0 for 3 cycles, then read addresses 0..3 → Prdata = 0, Pready = 1 with no waits, s2m = 0.
- Fast write/read: write 0x0042 to addr 1 → Pready in the first access cycle, s2m = 0x0042; then read addr 1 → Prdata = 0x0042, zero waits.
- Slow path: write 0x1234 to addr 2 → Pready low for exactly 2 access cycles and high on the 3rd, s2m = 0x1234; read addr 2 → same 2-wait pattern, Prdata = 0x1234.
- Error: with DEPTH = 4, write 0x0011 to addr 5 → Pready = 1 and Pslverr = 1 in the first access cycle, s2m unchanged; then read addr 5 → Prdata = 0, Pslverr = 1.
- Abort and reset: start a slow write of 0x0300 to addr 3 and drop Psel in the first wait cycle → addr 3 keeps its old value. Repeat with Prst pulsed low instead → all registers = 0 and FSM in IDLE.
- Parameter sweep: DATA_W = 32, DEPTH = 8, WAIT_CYCLES = 0 → write 0xFFFF_FFFF to addr 7 completes with zero waits and reads back 0xFFFF_FFFF.
